// File: rtl/serdesphy_tx_nibble_serializer.sv
// rtl/serdesphy_tx_nibble_serializer.sv - TX nibble FIFO, source select (FIFO/PRBS7/idle) and LSB-first serializer.
// Optional TX_PRBS_ERR_INJECT_EN adds prbs_err_inject for single-bit PRBS error injection.
module serdesphy_tx_nibble_serializer #(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [3:0] IDLE_NIBBLE = 4'h5,
  parameter logic [6:0] PRBS_SEED   = 7'h7F
) (
  input  logic       clk_240m_tx,
  input  logic       rst_240m_tx,
  input  logic       tx_en,
  input  logic       tx_fifo_en,
  input  logic       tx_prbs_en,
  input  logic       tx_data_sel,
  input  logic       tx_idle,
  input  logic [3:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       clear_sticky,
`ifdef TX_PRBS_ERR_INJECT_EN
  input  logic       prbs_err_inject,
`endif
  output logic       tx_serial_data,
  output logic       tx_serial_valid,
  output logic       tx_idle_pattern,
  output logic       tx_fifo_full,
  output logic       tx_fifo_empty,
  output logic       tx_overflow,
  output logic       tx_underflow,
  output logic       tx_active,
  output logic       tx_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [1:0]    bit_cnt;
  logic [2:0]    shreg;
  logic          prev_fifo;
  logic          boundary;

  logic [6:0]    lfsr;
  logic [6:0]    lfsr_next;
  logic [3:0]    prbs_nib;
  logic [3:0]    prbs_out;

  logic          sel_prbs;
  logic          fifo_path;
  logic          sel_fifo;
  logic [3:0]    nib;
  logic          overflow_set;
  logic          underflow_set;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign tx_ready = tx_fifo_en & ~full;
  assign push     = tx_valid & tx_ready;
  assign boundary = tx_en & (bit_cnt == 2'd0);

  // Source priority: idle override, then PRBS, then FIFO, otherwise idle fill.
  assign sel_prbs  = ~tx_idle & tx_data_sel & tx_prbs_en;
  assign fifo_path = ~tx_idle & ~(tx_data_sel & tx_prbs_en) & tx_fifo_en;
  assign sel_fifo  = fifo_path & ~empty;
  assign pop       = boundary & sel_fifo;

  assign overflow_set  = tx_valid & full;
  assign underflow_set = boundary & prev_fifo & fifo_path & empty;

  always_comb begin
    lfsr_next = lfsr;
    prbs_nib  = '0;
    for (int i = 0; i < 4; i++) begin
      prbs_nib[i] = lfsr_next[6] ^ lfsr_next[5];
      lfsr_next   = {lfsr_next[5:0], prbs_nib[i]};
    end
  end

`ifdef TX_PRBS_ERR_INJECT_EN
  logic inj_flag;

  // Armed by a pulse, consumed by the next PRBS nibble; the LFSR itself is never touched.
  always_ff @(posedge clk_240m_tx) begin
    if (rst_240m_tx || !tx_prbs_en) begin
      inj_flag <= 1'b0;
    end else if (prbs_err_inject) begin
      inj_flag <= 1'b1;
    end else if (boundary && sel_prbs) begin
      inj_flag <= 1'b0;
    end
  end

  assign prbs_out = prbs_nib ^ {3'b000, inj_flag};
`else
  assign prbs_out = prbs_nib;
`endif

  always_comb begin
    nib = IDLE_NIBBLE;
    if (sel_prbs) begin
      nib = prbs_out;
    end else if (sel_fifo) begin
      nib = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_240m_tx) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk_240m_tx) begin
    if (rst_240m_tx || !tx_fifo_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Disabling the stage truncates the current nibble; the next enable starts on a boundary.
  always_ff @(posedge clk_240m_tx) begin
    if (rst_240m_tx || !tx_en) begin
      bit_cnt         <= 2'd0;
      shreg           <= 3'b000;
      tx_serial_data  <= 1'b0;
      tx_serial_valid <= 1'b0;
      tx_idle_pattern <= 1'b0;
      tx_active       <= 1'b0;
      prev_fifo       <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 2'd1;
      if (boundary) begin
        tx_serial_data  <= nib[0];
        shreg           <= nib[3:1];
        tx_serial_valid <= 1'b1;
        tx_idle_pattern <= ~(sel_prbs | sel_fifo);
        tx_active       <= sel_prbs | sel_fifo;
        prev_fifo       <= sel_fifo;
      end else begin
        tx_serial_data <= shreg[0];
        shreg          <= {1'b0, shreg[2:1]};
      end
    end
  end

  always_ff @(posedge clk_240m_tx) begin
    if (rst_240m_tx || !tx_prbs_en) begin
      lfsr <= PRBS_SEED;
    end else if (boundary && sel_prbs) begin
      lfsr <= lfsr_next;
    end
  end

  always_ff @(posedge clk_240m_tx) begin
    if (rst_240m_tx) begin
      tx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      tx_overflow  <= overflow_set  | (tx_overflow  & ~clear_sticky);
      tx_underflow <= underflow_set | (tx_underflow & ~clear_sticky);
    end
  end

  assign tx_fifo_full  = full;
  assign tx_fifo_empty = empty;
  assign tx_error      = tx_overflow | tx_underflow;

endmodule

// File: tb/tb_serdesphy_tx_nibble_serializer.sv
// tb/tb_serdesphy_tx_nibble_serializer.sv - directed self-checking bench for serdesphy_tx_nibble_serializer.
module tb_serdesphy_tx_nibble_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       tx_fifo_en = 1'b0;
  logic       tx_prbs_en = 1'b0;
  logic       tx_data_sel = 1'b0;
  logic       tx_idle = 1'b0;
  logic [3:0] tx_data = 4'h0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       clear_sticky = 1'b0;
  logic       inj = 1'b0;
  logic       tx_serial_data;
  logic       tx_serial_valid;
  logic       tx_idle_pattern;
  logic       tx_fifo_full;
  logic       tx_fifo_empty;
  logic       tx_overflow;
  logic       tx_underflow;
  logic       tx_active;
  logic       tx_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serdesphy_tx_nibble_serializer dut (
    .clk_240m_tx     (clk),
    .rst_240m_tx     (rst),
    .tx_en           (tx_en),
    .tx_fifo_en      (tx_fifo_en),
    .tx_prbs_en      (tx_prbs_en),
    .tx_data_sel     (tx_data_sel),
    .tx_idle         (tx_idle),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .clear_sticky    (clear_sticky),
`ifdef TX_PRBS_ERR_INJECT_EN
    .prbs_err_inject (inj),
`endif
    .tx_serial_data  (tx_serial_data),
    .tx_serial_valid (tx_serial_valid),
    .tx_idle_pattern (tx_idle_pattern),
    .tx_fifo_full    (tx_fifo_full),
    .tx_fifo_empty   (tx_fifo_empty),
    .tx_overflow     (tx_overflow),
    .tx_underflow    (tx_underflow),
    .tx_active       (tx_active),
    .tx_error        (tx_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after a boundary edge; leaves 1 time unit after the next boundary edge.
  task automatic get_nibble(output logic [3:0] n, output logic act, output logic idl, output logic vld);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n[i] = tx_serial_data;
      if (i == 0) begin
        act = tx_active;
        idl = tx_idle_pattern;
        vld = tx_serial_valid;
      end
      @(posedge clk);
      #1;
      if (i == 0) inj = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({tx_serial_data, tx_serial_valid, tx_idle_pattern, tx_active} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_serial got=%b exp=0000", {tx_serial_data, tx_serial_valid, tx_idle_pattern, tx_active});
    end
    checks++;
    if ({tx_fifo_full, tx_fifo_empty, tx_overflow, tx_underflow, tx_error, tx_ready} !== 6'b010000) begin
      failures++;
      $display("FAIL reset_status got=%b exp=010000",
               {tx_fifo_full, tx_fifo_empty, tx_overflow, tx_underflow, tx_error, tx_ready});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] n;
    logic a, i, v;
    tx_fifo_en = 1'b1;
    tx_data = 4'hC;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    checks++;
    if (tx_fifo_empty !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_push empty=%b ready=%b exp empty=0 ready=1", tx_fifo_empty, tx_ready);
    end
    tx_en = 1'b1;
    step();
    get_nibble(n, a, i, v);
    checks++;
    if ({n, a, i, v} !== {4'hC, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL basic_nibble got n=%h act=%b idl=%b vld=%b exp n=c act=1 idl=0 vld=1", n, a, i, v);
    end
    get_nibble(n, a, i, v);
    checks++;
    if ({n, a, i} !== {4'h5, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL basic_idle got n=%h act=%b idl=%b exp n=5 act=0 idl=1", n, a, i);
    end
    checks++;
    if (tx_underflow !== 1'b1) begin
      failures++;
      $display("FAIL basic_underflow got=%b exp=1", tx_underflow);
    end
    tx_en = 1'b0;
    pulse_clear();
    checks++;
    if ({tx_serial_valid, tx_active, tx_underflow} !== 3'b000) begin
      failures++;
      $display("FAIL basic_disable got=%b exp=000", {tx_serial_valid, tx_active, tx_underflow});
    end
  endtask

  task automatic test_overflow();
    logic [3:0] n;
    logic a, i, v;
    tx_fifo_en = 1'b0;
    step();
    tx_fifo_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tx_data = 4'(k);
      tx_valid = 1'b1;
      if (k == 9) begin
        checks++;
        if (tx_fifo_full !== 1'b1 || tx_ready !== 1'b0) begin
          failures++;
          $display("FAIL ovf_full full=%b ready=%b exp full=1 ready=0", tx_fifo_full, tx_ready);
        end
      end
      step();
    end
    tx_valid = 1'b0;
    checks++;
    if ({tx_overflow, tx_error, tx_fifo_full} !== 3'b111) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=111", {tx_overflow, tx_error, tx_fifo_full});
    end
    pulse_clear();
    checks++;
    if ({tx_overflow, tx_underflow, tx_error} !== 3'b000) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=000", {tx_overflow, tx_underflow, tx_error});
    end
    tx_en = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      get_nibble(n, a, i, v);
      checks++;
      if (n !== 4'(k) || a !== 1'b1) begin
        failures++;
        $display("FAIL ovf_drain%0d got n=%h act=%b exp n=%h act=1", k, n, a, 4'(k));
      end
    end
    checks++;
    if (tx_underflow !== 1'b1 || tx_fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drain_end underflow=%b empty=%b exp 1 1", tx_underflow, tx_fifo_empty);
    end
    get_nibble(n, a, i, v);
    checks++;
    if (n !== 4'h5 || i !== 1'b1) begin
      failures++;
      $display("FAIL ovf_dropped got n=%h idl=%b exp n=5 idl=1", n, i);
    end
    tx_en = 1'b0;
    pulse_clear();
  endtask

  task automatic test_prbs();
    logic [3:0] n;
    logic a, i, v;
    logic [6:0] r;
    logic [3:0] exp_n;
    logic [3:0] stream [0:128];
    int bad;
    r = 7'h7F;
    bad = 0;
    tx_prbs_en = 1'b1;
    tx_data_sel = 1'b1;
    tx_en = 1'b1;
    step();
    for (int k = 0; k <= 128; k++) begin
      get_nibble(n, a, i, v);
      stream[k] = n;
      for (int b = 0; b < 4; b++) begin
        exp_n[b] = r[6] ^ r[5];
        r = {r[5:0], exp_n[b]};
      end
      if (k == 0) begin
        checks++;
        if (n !== 4'h0 || a !== 1'b1 || i !== 1'b0) begin
          failures++;
          $display("FAIL prbs_first got n=%h act=%b idl=%b exp n=0 act=1 idl=0", n, a, i);
        end
      end
      if (k == 1) begin
        checks++;
        if (n !== 4'h4) begin
          failures++;
          $display("FAIL prbs_second got=%h exp=4", n);
        end
      end
      if (n !== exp_n) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL prbs_stream bad_nibbles=%0d exp=0", bad);
    end
    checks++;
    if (stream[127] !== stream[0] || stream[128] !== stream[1]) begin
      failures++;
      $display("FAIL prbs_period got %h%h exp %h%h", stream[127], stream[128], stream[0], stream[1]);
    end
    tx_en = 1'b0;
    tx_prbs_en = 1'b0;
    tx_data_sel = 1'b0;
    step();
  endtask

  task automatic test_underflow_idle();
    logic [3:0] n0, n1, n2;
    logic a, i, v;
    tx_data = 4'hA;
    tx_valid = 1'b1;
    step();
    tx_data = 4'hB;
    step();
    tx_valid = 1'b0;
    tx_en = 1'b1;
    step();
    get_nibble(n0, a, i, v);
    get_nibble(n1, a, i, v);
    checks++;
    if (n0 !== 4'hA || n1 !== 4'hB) begin
      failures++;
      $display("FAIL uf_stream got %h %h exp a b", n0, n1);
    end
    checks++;
    if (tx_underflow !== 1'b1) begin
      failures++;
      $display("FAIL uf_third_boundary got=%b exp=1", tx_underflow);
    end
    get_nibble(n2, a, i, v);
    checks++;
    if (n2 !== 4'h5 || i !== 1'b1) begin
      failures++;
      $display("FAIL uf_idle got n=%h idl=%b exp n=5 idl=1", n2, i);
    end
    tx_en = 1'b0;
    pulse_clear();
    tx_data = 4'h3;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_idle = 1'b1;
    tx_en = 1'b1;
    step();
    get_nibble(n0, a, i, v);
    checks++;
    if ({n0, a, i} !== {4'h5, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL idle_force got n=%h act=%b idl=%b exp n=5 act=0 idl=1", n0, a, i);
    end
    checks++;
    if (tx_fifo_empty !== 1'b0 || tx_underflow !== 1'b0) begin
      failures++;
      $display("FAIL idle_nopop empty=%b underflow=%b exp 0 0", tx_fifo_empty, tx_underflow);
    end
    tx_en = 1'b0;
    tx_idle = 1'b0;
    step();
  endtask

  task automatic test_mid_reset();
    logic [3:0] n0, n1;
    logic a, i, v;
    tx_valid = 1'b1;
    tx_data = 4'h7;
    step();
    step();
    tx_valid = 1'b0;
    tx_prbs_en = 1'b1;
    tx_data_sel = 1'b1;
    tx_en = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({tx_serial_data, tx_serial_valid, tx_idle_pattern, tx_active} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid_serial got=%b exp=0000", {tx_serial_data, tx_serial_valid, tx_idle_pattern, tx_active});
    end
    checks++;
    if ({tx_fifo_full, tx_fifo_empty, tx_overflow, tx_underflow, tx_error} !== 5'b01000) begin
      failures++;
      $display("FAIL rst_mid_status got=%b exp=01000",
               {tx_fifo_full, tx_fifo_empty, tx_overflow, tx_underflow, tx_error});
    end
    rst = 1'b0;
    step();
    get_nibble(n0, a, i, v);
    get_nibble(n1, a, i, v);
    checks++;
    if (n0 !== 4'h0 || n1 !== 4'h4) begin
      failures++;
      $display("FAIL rst_mid_seed got %h %h exp 0 4", n0, n1);
    end
    tx_en = 1'b0;
    tx_prbs_en = 1'b0;
    tx_data_sel = 1'b0;
    step();
  endtask

`ifdef TX_PRBS_ERR_INJECT_EN
  task automatic test_err_inject();
    logic [3:0] n;
    logic [3:0] ref_n [0:4];
    logic [3:0] exp_n;
    logic [6:0] r;
    logic a, i, v;
    r = 7'h7F;
    for (int k = 0; k <= 4; k++) begin
      for (int b = 0; b < 4; b++) begin
        ref_n[k][b] = r[6] ^ r[5];
        r = {r[5:0], ref_n[k][b]};
      end
    end
    tx_prbs_en = 1'b1;
    tx_data_sel = 1'b1;
    tx_en = 1'b1;
    step();
    for (int k = 0; k <= 4; k++) begin
      if (k == 1) inj = 1'b1;
      get_nibble(n, a, i, v);
      exp_n = (k == 2) ? (ref_n[k] ^ 4'h1) : ref_n[k];
      checks++;
      if (n !== exp_n) begin
        failures++;
        $display("FAIL inject_nib%0d got=%h exp=%h", k, n, exp_n);
      end
    end
    tx_en = 1'b0;
    tx_prbs_en = 1'b0;
    tx_data_sel = 1'b0;
    step();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_prbs();
    test_underflow_idle();
    test_mid_reset();
`ifdef TX_PRBS_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
